// File: rtl/pixel_writer.sv
// Pixel writer: buffers sprite pixels, clips them to the visible frame and turns them into framebuffer writes.
// It also performs whole-frame clears after the pixels already queued have been written.
module pixel_writer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [7:0]  color,
  input  logic        plot,
  output logic        ready,
  input  logic        clear_req,
  input  logic [7:0]  clear_color,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        busy,
  output logic        done_clear,
  output logic [7:0]  drop_count
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [8:0]    W_LIM     = 9'(WIDTH);
  localparam logic [7:0]    H_LIM     = 8'(HEIGHT);
  localparam logic [14:0]   W15       = 15'(WIDTH);
  localparam logic [14:0]   LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [22:0]   fifo_mem_q [FIFO_DEPTH];
  logic [14:0]   clr_addr_q, clr_addr_d;
  logic [7:0]    clr_color_q, clr_color_d;
  logic [14:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic          done_clear_q, done_clear_d;
  logic [7:0]    drop_q, drop_d;

  logic          empty_s, full_s, accept_s, in_range_s, push_s, pop_s;
  logic [22:0]   head_s;
  logic [14:0]   head_addr_s;

  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ready      = (state_q == ST_RUN) && !full_s;
  assign busy       = (state_q != ST_RUN) || !empty_s;
  assign accept_s   = plot && ready;
  assign in_range_s = ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  assign push_s     = accept_s && in_range_s;
  // The FIFO is only ever non-empty in RUN or DRAIN, so popping there drains it completely.
  assign pop_s      = !empty_s && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign head_s     = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign head_addr_s = ({8'd0, head_s[14:8]} * W15) + {7'd0, head_s[22:15]};

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign done_clear = done_clear_q;
  assign drop_count = drop_q;

  // Pixel storage; entries are {x, y, color}.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {x, y, color};
    end
  end

  // Next-state logic for the FSM, FIFO pointers, drop counter and write port.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    clr_addr_d   = clr_addr_q;
    clr_color_d  = clr_color_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    done_clear_d = 1'b0;
    drop_d       = drop_q;

    if (accept_s && !in_range_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      mem_we_d   = 1'b1;
      mem_addr_d = head_addr_s;
      mem_data_d = head_s[7:0];
    end else begin
      rd_ptr_d   = rd_ptr_q;
    end

    case (state_q)
      ST_RUN: begin
        if (clear_req) begin
          clr_color_d = clear_color;
          state_d     = ST_DRAIN;
        end else begin
          state_d     = ST_RUN;
        end
      end
      // An empty FIFO here means the final pop was registered on the previous edge.
      ST_DRAIN: begin
        if (empty_s) begin
          clr_addr_d = 15'd0;
          state_d    = ST_CLEAR;
        end else begin
          state_d    = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        mem_we_d   = 1'b1;
        mem_addr_d = clr_addr_q;
        mem_data_d = clr_color_q;
        if (clr_addr_q == LAST_ADDR) begin
          done_clear_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          clr_addr_d   = clr_addr_q + 15'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      clr_addr_q   <= 15'd0;
      clr_color_q  <= 8'd0;
      mem_addr_q   <= 15'd0;
      mem_data_q   <= 8'd0;
      mem_we_q     <= 1'b0;
      done_clear_q <= 1'b0;
      drop_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      clr_addr_q   <= clr_addr_d;
      clr_color_q  <= clr_color_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      done_clear_q <= done_clear_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: each accepted pixel or clear pushes its expected writes,
// and the write monitor pops and compares them.
module tb_pixel_writer;

  localparam int W = 160;
  localparam int H = 120;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  x, color, clear_color;
  logic [6:0]  y;
  logic        plot, clear_req;
  logic        ready, mem_we, busy, done_clear;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data, drop_count;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   drop_exp = 0;

  pixel_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .color(color), .plot(plot),
    .ready(ready), .clear_req(clear_req), .clear_color(clear_color),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .busy(busy),
    .done_clear(done_clear), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset && mem_we) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(e.addr));
        check_eq("wr_data", 32'(mem_data), 32'(e.data));
        if (e.cyc >= 0) check_eq("wr_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (reset && done_clear) done_cnt++;
  end

  task automatic push_clear(input logic [7:0] cc);
    for (int a = 0; a < W * H; a++) begin
      exp_t e;
      e.addr = 15'(a);
      e.data = cc;
      e.cyc  = -1;
      sb_q.push_back(e);
    end
  endtask

  task automatic put_pixel(input logic [7:0] px, input logic [6:0] py, input logic [7:0] pc,
                           input logic clr, input logic [7:0] cc, output int waited);
    int n = 0;
    @(negedge clock);
    x = px; y = py; color = pc; plot = 1'b1; clear_req = clr; clear_color = cc;
    while (!ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check_eq("accept_timeout", 32'(ready), 32'd1);
    waited = n;
    if (int'(px) < W && int'(py) < H) begin
      exp_t e;
      e.addr = 15'(int'(py) * W + int'(px));
      e.data = pc;
      e.cyc  = cyc + 2;
      sb_q.push_back(e);
    end else if (drop_exp < 255) begin
      drop_exp++;
    end
    if (clr) push_clear(cc);
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    plot = 1'b0; clear_req = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int w;
    logic [7:0] sx [6] = '{8'd0, 8'd159, 8'd17, 8'd80, 8'd1, 8'd42};
    logic [6:0] sy [6] = '{7'd0, 7'd0, 7'd33, 7'd119, 7'd60, 7'd7};
    logic [7:0] sc [6] = '{8'h01, 8'hFE, 8'h5A, 8'hC3, 8'h77, 8'h08};
    bit found;

    reset = 1'b0; x = '0; y = '0; color = '0; plot = 1'b0; clear_req = 1'b0; clear_color = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_data", 32'(mem_data), 32'd0);
    check_eq("rst_done", 32'(done_clear), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("ready_after_rst", 32'(ready), 32'd1);

    // Single pixel: (3,2) -> 323.
    put_pixel(8'd3, 7'd2, 8'hAA, 1'b0, 8'h00, w);
    idle(5);
    check_eq("single_drained", 32'(sb_q.size()), 32'd0);

    // Back-to-back stream at one pixel per cycle never stalls.
    for (int i = 0; i < 6; i++) begin
      put_pixel(sx[i], sy[i], sc[i], 1'b0, 8'h00, w);
      check_eq("stream_no_stall", 32'(w), 32'd0);
    end
    idle(6);
    check_eq("stream_drained", 32'(sb_q.size()), 32'd0);
    check_eq("stream_busy", 32'(busy), 32'd0);

    // Clipping at the frame edges.
    put_pixel(8'd160, 7'd0, 8'h10, 1'b0, 8'h00, w);
    put_pixel(8'd0, 7'd120, 8'h20, 1'b0, 8'h00, w);
    put_pixel(8'd159, 7'd119, 8'h30, 1'b0, 8'h00, w);
    idle(5);
    check_eq("clip_drop", 32'(drop_count), 32'(drop_exp));
    check_eq("clip_drained", 32'(sb_q.size()), 32'd0);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) put_pixel(8'd200, 7'd0, 8'h44, 1'b0, 8'h00, w);
      else            put_pixel(8'd0, 7'd127, 8'h44, 1'b0, 8'h00, w);
    end
    idle(5);
    check_eq("sat_drop", 32'(drop_count), 32'(drop_exp));

    // Clear with a pixel accepted in the same cycle; clear_req is pulsed mid-sweep and must be ignored.
    put_pixel(8'd5, 7'd5, 8'h11, 1'b1, 8'h00, w);
    idle(100);
    clear_req = 1'b1; clear_color = 8'hFF;
    repeat (3) @(negedge clock);
    clear_req = 1'b0;
    for (int i = 0; i < 20000 && sb_q.size() != 0; i++) @(negedge clock);
    check_eq("clear_complete", 32'(sb_q.size()), 32'd0);
    repeat (4) @(negedge clock);
    check_eq("clear_done_once", 32'(done_cnt), 32'd1);
    check_eq("clear_ready_after", 32'(ready), 32'd1);
    check_eq("clear_busy_after", 32'(busy), 32'd0);

    // Abort a sweep with reset after address 1000.
    @(negedge clock);
    clear_req = 1'b1; clear_color = 8'h5A;
    push_clear(8'h5A);
    @(negedge clock);
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clock);
      if (mem_we && mem_addr == 15'd1000) found = 1'b1;
    end
    check_eq("abort_reached_1000", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_we", 32'(mem_we), 32'd0);
    check_eq("abort_done", 32'(done_clear), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(ready), 32'd1);
    sb_q.delete();
    drop_exp = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check_eq("abort_no_done", 32'(done_cnt), 32'd1);
    check_eq("abort_ready_after", 32'(ready), 32'd1);
    check_eq("abort_busy_after", 32'(busy), 32'd0);
    check_eq("abort_drop", 32'(drop_count), 32'(drop_exp));

    // Normal operation resumes.
    put_pixel(8'd7, 7'd1, 8'h3C, 1'b0, 8'h00, w);
    idle(5);
    check_eq("post_abort_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
